// File: rtl/pkt_merger.sv
// pkt_merger: packet-atomic round-robin merge of the data path and the
// FIFO-buffered control path onto one registered AXI-Stream output.
module pkt_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CTRL_FIFO_DEPTH_BITS = 5
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
    input  logic                              ctrl_s_axis_tvalid,
    input  logic                              ctrl_s_axis_tlast,
    output logic                              ctrl_s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [31:0]                       data_pkt_cnt,
    output logic [31:0]                       ctrl_pkt_cnt
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int KW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int AB    = CTRL_FIFO_DEPTH_BITS;
    localparam int FW    = DW + KW + UW + 1;
    localparam int DEPTH = 1 << AB;
    localparam logic [AB:0] NEAR_FULL_LVL = (AB+1)'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_DATA = 2'd1;
    localparam logic [1:0] ST_SEND_CTRL = 2'd2;

    logic [FW-1:0] fifo_mem_r [DEPTH];
    logic [AB-1:0] wr_ptr_r;
    logic [AB-1:0] rd_ptr_r;
    logic [AB:0]   fifo_count_r;
    logic          fifo_empty_s;
    logic          nearly_full_s;
    logic          fifo_wr_s;
    logic          fifo_rd_s;
    logic          ctrl_avail_s;
    logic [FW-1:0] fifo_din_s;
    logic [FW-1:0] fifo_head_s;
    logic [DW-1:0] head_tdata_s;
    logic [KW-1:0] head_tkeep_s;
    logic [UW-1:0] head_tuser_s;
    logic          head_tlast_s;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          last_grant_r;
    logic          last_grant_nxt_s;
    logic          adv_s;
    logic          data_take_s;
    logic          load_s;

    logic [DW-1:0] load_tdata_s;
    logic [KW-1:0] load_tkeep_s;
    logic [UW-1:0] load_tuser_s;
    logic          load_tlast_s;

    logic [DW-1:0] m_tdata_r;
    logic [KW-1:0] m_tkeep_r;
    logic [UW-1:0] m_tuser_r;
    logic          m_tvalid_r;
    logic          m_tlast_r;
    logic          out_src_r;
    logic [31:0]   data_pkt_cnt_r;
    logic [31:0]   ctrl_pkt_cnt_r;

    assign fifo_empty_s  = (fifo_count_r == '0);
    assign nearly_full_s = (fifo_count_r >= NEAR_FULL_LVL);
    assign fifo_wr_s     = ctrl_s_axis_tvalid & ~nearly_full_s;
    assign fifo_din_s    = {ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tlast};
    assign fifo_head_s   = fifo_mem_r[rd_ptr_r];
    assign head_tdata_s  = fifo_head_s[FW-1 -: DW];
    assign head_tkeep_s  = fifo_head_s[FW-DW-1 -: KW];
    assign head_tuser_s  = fifo_head_s[UW:1];
    assign head_tlast_s  = fifo_head_s[0];

    // A beat being written this cycle already counts as pending for arbitration.
    assign ctrl_avail_s  = ~fifo_empty_s | fifo_wr_s;

    assign adv_s         = ~m_tvalid_r | m_axis_tready;
    assign data_take_s   = (state_r == ST_SEND_DATA) & s_axis_tvalid & adv_s;
    assign fifo_rd_s     = (state_r == ST_SEND_CTRL) & adv_s & ~fifo_empty_s;
    assign load_s        = data_take_s | fifo_rd_s;

    assign s_axis_tready      = (state_r == ST_SEND_DATA) & adv_s;
    assign ctrl_s_axis_tready = ~nearly_full_s;

    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tkeep  = m_tkeep_r;
    assign m_axis_tuser  = m_tuser_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;
    assign data_pkt_cnt  = data_pkt_cnt_r;
    assign ctrl_pkt_cnt  = ctrl_pkt_cnt_r;

    // Control FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_mem_r[wr_ptr_r] <= fifo_din_s;
        end
    end

    // Control FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
        end else begin
            if (fifo_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AB'(1);
            end
            if (fifo_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AB'(1);
            end
            case ({fifo_wr_s, fifo_rd_s})
                2'b10:   fifo_count_r <= fifo_count_r + (AB+1)'(1);
                2'b01:   fifo_count_r <= fifo_count_r - (AB+1)'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // Packet-level arbitration and send-state sequencing.
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (s_axis_tvalid && ctrl_avail_s) begin
                    if (last_grant_r) begin
                        state_nxt_s      = ST_SEND_DATA;
                        last_grant_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s      = ST_SEND_CTRL;
                        last_grant_nxt_s = 1'b1;
                    end
                end else if (s_axis_tvalid) begin
                    state_nxt_s      = ST_SEND_DATA;
                    last_grant_nxt_s = 1'b0;
                end else if (ctrl_avail_s) begin
                    state_nxt_s      = ST_SEND_CTRL;
                    last_grant_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND_DATA: begin
                if (data_take_s && s_axis_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND_DATA;
                end
            end
            ST_SEND_CTRL: begin
                if (fifo_rd_s && head_tlast_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SEND_CTRL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Select which source feeds the output register this cycle.
    always_comb begin
        load_tdata_s = s_axis_tdata;
        load_tkeep_s = s_axis_tkeep;
        load_tuser_s = s_axis_tuser;
        load_tlast_s = s_axis_tlast;
        if (fifo_rd_s) begin
            load_tdata_s = head_tdata_s;
            load_tkeep_s = head_tkeep_s;
            load_tuser_s = head_tuser_s;
            load_tlast_s = head_tlast_s;
        end else begin
            load_tdata_s = s_axis_tdata;
            load_tkeep_s = s_axis_tkeep;
            load_tuser_s = s_axis_tuser;
            load_tlast_s = s_axis_tlast;
        end
    end

    // Output register: loads on a take, holds under back-pressure, drains otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tdata_r  <= '0;
            m_tkeep_r  <= '0;
            m_tuser_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            out_src_r  <= 1'b0;
        end else if (load_s) begin
            m_tdata_r  <= load_tdata_s;
            m_tkeep_r  <= load_tkeep_s;
            m_tuser_r  <= load_tuser_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= load_tlast_s;
            out_src_r  <= fifo_rd_s;
        end else if (m_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    // Per-source packet counters, bumped when a last beat leaves the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_pkt_cnt_r <= 32'd0;
            ctrl_pkt_cnt_r <= 32'd0;
        end else if (m_tvalid_r && m_axis_tready && m_tlast_r) begin
            if (out_src_r) begin
                ctrl_pkt_cnt_r <= ctrl_pkt_cnt_r + 32'd1;
            end else begin
                data_pkt_cnt_r <= data_pkt_cnt_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_merger.sv
// Bench for pkt_merger: random data/control traffic scored per source (source
// tag carried in tdata[255]), plus directed arbitration, fill, reset and wrap cases.
`timescale 1ns/1ps
module tb_pkt_merger;
    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] ctrl_s_axis_tdata = '0;
    logic [KW-1:0] ctrl_s_axis_tkeep = '0;
    logic [UW-1:0] ctrl_s_axis_tuser = '0;
    logic          ctrl_s_axis_tvalid = 1'b0;
    logic          ctrl_s_axis_tlast = 1'b0;
    logic          ctrl_s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [31:0]   data_pkt_cnt;
    logic [31:0]   ctrl_pkt_cnt;

    pkt_merger dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .ctrl_s_axis_tdata(ctrl_s_axis_tdata), .ctrl_s_axis_tkeep(ctrl_s_axis_tkeep),
        .ctrl_s_axis_tuser(ctrl_s_axis_tuser), .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
        .ctrl_s_axis_tlast(ctrl_s_axis_tlast), .ctrl_s_axis_tready(ctrl_s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .data_pkt_cnt(data_pkt_cnt), .ctrl_pkt_cnt(ctrl_pkt_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_data_q[$];
    beat_t       exp_ctrl_q[$];
    int          src_log[$];
    logic [31:0] exp_data_cnt = 32'd0;
    logic [31:0] exp_ctrl_cnt = 32'd0;
    int          rdy_mode = 0;
    int          ctrl_accepted = 0;
    bit          in_pkt = 1'b0;
    bit          cur_src = 1'b0;
    bit          stall_prev = 1'b0;
    beat_t       held;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, expected completion", name);
    endtask

    function automatic beat_t mk_beat(input bit is_ctrl, input bit last);
        beat_t b;
        for (int w = 0; w < 8; w++) b.d[w*32 +: 32] = $urandom();
        b.d[DW-1] = is_ctrl;
        b.k = $urandom();
        b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.l = last;
        return b;
    endfunction

    // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled.
    initial forever begin
        @(posedge clk); #2;
        case (rdy_mode)
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            2:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'b1;
        endcase
    end

    task automatic send_data_pkt(input int n, input int gap_max, input bit directed);
        beat_t b;
        int    waited;
        bit    hs;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(1'b0, (i == n - 1));
            if (directed) b.d = DW'(i + 1);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            exp_data_q.push_back(b);
            s_axis_tdata = b.d; s_axis_tkeep = b.k; s_axis_tuser = b.u; s_axis_tlast = b.l;
            s_axis_tvalid = 1'b1;
            waited = 0; hs = 1'b0;
            while (!hs && waited < 2000) begin
                @(negedge clk); hs = s_axis_tready;
                @(posedge clk); #1; waited++;
            end
            if (!hs) fail_now("data_handshake");
            else chk("data_latency", m_axis_tdata, b.d);
            s_axis_tvalid = 1'b0;
        end
        exp_data_cnt++;
    endtask

    task automatic send_ctrl_pkt(input int n, input int gap_max);
        beat_t b;
        int    waited;
        bit    hs;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(1'b1, (i == n - 1));
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            exp_ctrl_q.push_back(b);
            ctrl_s_axis_tdata = b.d; ctrl_s_axis_tkeep = b.k; ctrl_s_axis_tuser = b.u;
            ctrl_s_axis_tlast = b.l; ctrl_s_axis_tvalid = 1'b1;
            waited = 0; hs = 1'b0;
            while (!hs && waited < 2000) begin
                @(negedge clk); hs = ctrl_s_axis_tready;
                @(posedge clk); #1; waited++;
            end
            if (!hs) fail_now("ctrl_handshake");
            else ctrl_accepted++;
            ctrl_s_axis_tvalid = 1'b0;
        end
        exp_ctrl_cnt++;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_data_q.size() != 0 || exp_ctrl_q.size() != 0 || m_axis_tvalid) && w < 3000) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 3000) fail_now("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        ctrl_s_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_data_q.delete(); exp_ctrl_q.delete();
        exp_data_cnt = 32'd0; exp_ctrl_cnt = 32'd0;
        reset = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_data_cnt"}, DW'(data_pkt_cnt), DW'(exp_data_cnt));
        chk({tag, "_ctrl_cnt"}, DW'(ctrl_pkt_cnt), DW'(exp_ctrl_cnt));
    endtask

    // Output monitor: scores each accepted beat against its source queue.
    initial begin : monitor
        beat_t obs;
        beat_t expb;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pkt = 1'b0;
                stall_prev = 1'b0;
            end else begin
                obs = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
                if (stall_prev) begin
                    chk_beat("hold_stable", obs, held);
                    chk("hold_valid", DW'(m_axis_tvalid), DW'(1));
                end
                if (m_axis_tvalid && !m_axis_tready) chk("sready_in_stall", DW'(s_axis_tready), '0);
                if (m_axis_tvalid && m_axis_tready) begin
                    if (!in_pkt) begin
                        cur_src = m_axis_tdata[DW-1];
                        src_log.push_back(int'(cur_src));
                        in_pkt = 1'b1;
                    end
                    if (cur_src ? (exp_ctrl_q.size() == 0) : (exp_data_q.size() == 0)) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", obs);
                    end else begin
                        expb = cur_src ? exp_ctrl_q.pop_front() : exp_data_q.pop_front();
                        chk_beat(cur_src ? "ctrl_beat" : "data_beat", obs, expb);
                    end
                    if (m_axis_tlast) in_pkt = 1'b0;
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                held = obs;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        beat_t b1;
        beat_t b2;
        int    w;
        bit    hs;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_m_tkeep", DW'(m_axis_tkeep), '0);
        chk("rst_m_tuser", DW'(m_axis_tuser), '0);
        chk("rst_m_tlast", DW'(m_axis_tlast), '0);
        chk("rst_s_tready", DW'(s_axis_tready), '0);
        chk("rst_ctrl_tready", DW'(ctrl_s_axis_tready), DW'(1));
        check_counters("rst");
        do_reset();

        // Directed 3-beat data packet with tdata 1,2,3
        rdy_mode = 0;
        send_data_pkt(3, 0, 1'b1);
        drain();
        check_counters("single_data");

        // Both sources loaded from reset: ctrl first, then strict alternation
        do_reset();
        src_log.delete();
        fork
            begin for (int p = 0; p < 3; p++) send_data_pkt(2, 0, 1'b0); end
            begin for (int p = 0; p < 3; p++) send_ctrl_pkt(2, 0); end
        join
        drain();
        for (int i = 0; i < 6; i++)
            chk("grant_order", DW'((i < src_log.size()) ? src_log[i] : 9), DW'((i % 2 == 0) ? 1 : 0));
        check_counters("alternate");

        // Random traffic with random downstream back-pressure
        rdy_mode = 1;
        fork
            begin for (int p = 0; p < 12; p++) send_data_pkt($urandom_range(1, 6), 3, 1'b0); end
            begin for (int p = 0; p < 12; p++) send_ctrl_pkt($urandom_range(1, 6), 3); end
        join
        rdy_mode = 0;
        drain();
        check_counters("random");

        // Control burst against a stalled output fills the FIFO
        rdy_mode = 2;
        @(posedge clk); #3;
        ctrl_accepted = 0;
        fork
            begin for (int p = 0; p < 5; p++) send_ctrl_pkt(8, 0); end
            begin
                repeat (60) @(posedge clk);
                #1;
                chk("ctrl_accepted_at_full", DW'(ctrl_accepted), DW'(32));
                chk("ctrl_tready_full", DW'(ctrl_s_axis_tready), '0);
                rdy_mode = 0;
            end
        join
        drain();
        check_counters("burst");

        // Reset on beat 2 of a data packet clears outputs asynchronously
        b1 = mk_beat(1'b0, 1'b0);
        b2 = mk_beat(1'b0, 1'b0);
        s_axis_tdata = b1.d; s_axis_tkeep = b1.k; s_axis_tuser = b1.u; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b1;
        w = 0; hs = 1'b0;
        while (!hs && w < 100) begin
            @(negedge clk); hs = s_axis_tready;
            @(posedge clk); #1; w++;
        end
        if (!hs) fail_now("reset_test_handshake");
        s_axis_tdata = b2.d; s_axis_tkeep = b2.k; s_axis_tuser = b2.u;
        #2;
        reset = 1'b1;
        #1;
        chk("async_m_tvalid", DW'(m_axis_tvalid), '0);
        chk("async_m_tdata", m_axis_tdata, '0);
        chk("async_m_tlast", DW'(m_axis_tlast), '0);
        chk("async_s_tready", DW'(s_axis_tready), '0);
        chk("async_ctrl_tready", DW'(ctrl_s_axis_tready), DW'(1));
        do_reset();
        send_ctrl_pkt(1, 0);
        drain();
        check_counters("after_reset");

        // Counter wrap from all-ones
        force dut.data_pkt_cnt_r = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.data_pkt_cnt_r;
        exp_data_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("cnt_preload", DW'(data_pkt_cnt), DW'(exp_data_cnt));
        send_data_pkt(1, 0, 1'b0);
        drain();
        check_counters("wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
